// File: rtl/array_collect_pkg.sv
// Shared types for array_collect: FSM state encoding and a slot-index width helper.
package array_collect_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } collect_state_t;

    // A slot index needs at least one bit even when a frame holds a single word.
    function automatic int idx_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/array_collect.sv
// Packs M consecutive N-bit words into an unpacked frame and hands it downstream over valid/ready.
// Optional ARRAY_COLLECT_FLUSH_EN adds a flush input to close partial frames and an out_count output.
module array_collect
    import array_collect_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 2
) (
    input  logic                     clock,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_data,
`ifdef ARRAY_COLLECT_FLUSH_EN
    input  logic                     flush,
    output logic [$clog2(M+1)-1:0]   out_count,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_data [0:M-1]
);

    localparam int IW = idx_width(M);

    collect_state_t state_reg;
    logic [IW-1:0]  idx_reg;
    logic [N-1:0]   slot_reg [0:M-1];

    logic in_xfer;
    logic out_xfer;
    logic last_word;
    logic close_frame;

    assign out_valid = (state_reg == FULL);
    assign in_ready  = (state_reg == FILL) || out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign last_word = in_xfer && (idx_reg == IW'(M - 1));

`ifdef ARRAY_COLLECT_FLUSH_EN
    localparam int CW = $clog2(M + 1);

    // An empty frame (idx 0, no word this cycle) is never closed by flush.
    assign close_frame = last_word || (flush && (in_xfer || (idx_reg != '0)));

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            out_count <= '0;
        end else if (state_reg == FILL && close_frame) begin
            out_count <= CW'(idx_reg) + CW'(in_xfer);
        end
    end
`else
    assign close_frame = last_word;
`endif

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_reg <= FILL;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (close_frame) begin
                        state_reg <= FULL;
                        idx_reg   <= '0;
                    end else if (in_xfer) begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end
                FULL: begin
                    // A word accepted alongside the drain already occupies slot 0.
                    if (out_xfer) begin
                        state_reg <= (in_xfer && M == 1) ? FULL : FILL;
                        idx_reg   <= (in_xfer && M > 1) ? IW'(1) : '0;
                    end
                end
                default: begin
                    state_reg <= FILL;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_slot
        always_ff @(posedge clock or negedge rstn) begin
            if (!rstn) begin
                slot_reg[gi] <= '0;
            end else if (out_xfer) begin
                slot_reg[gi] <= (gi == 0 && in_xfer) ? in_data : '0;
            end else if (state_reg == FILL && in_xfer && idx_reg == IW'(gi)) begin
                slot_reg[gi] <= in_data;
            end
        end
        assign out_data[gi] = slot_reg[gi];
    end

endmodule
